// File: rtl/apb_master_bridge_if.sv
// Request/response handshake and APB bus signals of the APB master bridge.
// The master modport is the bridge side; the slave modport is the requester/APB slave side.
interface apb_master_bridge_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB master bridge: one request at a time, full SETUP/ACCESS transfer, registered response.
// Optional ACCESS wait-state timeout is compiled in with `define APB_MST_TIMEOUT_EN.
//
// state    | meaning
// S_IDLE   | ready for a request
// S_SETUP  | APB setup phase (PSEL=1, PENABLE=0)
// S_ACCESS | APB access phase, waiting for PREADY
// S_RESP   | response held until consumed
module apb_master_bridge #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    apb_master_bridge_if.master  bus
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
`ifdef APB_MST_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  wait_cnt_q, wait_cnt_d;
`endif

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_MST_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_MST_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_MST_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    // APB address/data registers are only touched for a real transfer
                    if (bus.req_addr[1:0] == 2'b00) begin
                        state_d  = S_SETUP;
                        psel_d   = 1'b1;
                        pwrite_d = bus.req_write;
                        paddr_d  = bus.req_addr;
                        pwdata_d = bus.req_write ? bus.req_wdata : 32'h0;
                    end else begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                    end
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                state_d   = S_ACCESS;
`ifdef APB_MST_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            S_ACCESS: begin
                if (bus.PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.PSLVERR;
                    rsp_rdata_d = (!pwrite_q && !bus.PSLVERR) ? bus.PRDATA : 32'h0;
                    state_d     = S_RESP;
                end
`ifdef APB_MST_TIMEOUT_EN
                else if (wait_cnt_q == TO_LAST) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'h0;
                    state_d     = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req_ready = req_ready_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: APB slave and requester driven from the bench,
// expected values hand-computed per transaction.
module tb_apb_master_bridge;

    logic PCLK;
    logic PRESET;
    int   n_checks = 0;
    int   n_errors = 0;

    apb_master_bridge_if bus();

    apb_master_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request at a negedge in IDLE, act as APB slave, then consume the response.
    // PREADY is raised on the (waits+1)-th PENABLE cycle; latency counts edges from the accept edge.
    task automatic run_xfer(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int waits, input logic slverr,
                            input logic [31:0] prd, input logic exp_err,
                            input logic [31:0] exp_rd, input int exp_lat,
                            input int exp_en, input int hold);
        int lat, en_cnt, sel_cnt;
        bit done;
        logic [31:0] exp_wd;
        exp_wd = wr ? wdata : 32'h0;
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        bus.req_valid = 1'b0;
        lat = 1; en_cnt = 0; sel_cnt = 0; done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (bus.PSEL) begin
                sel_cnt++;
                chk({tag, "_paddr"}, bus.PADDR, addr);
                chk({tag, "_pwrite"}, 32'(bus.PWRITE), 32'(wr));
                chk({tag, "_pwdata"}, bus.PWDATA, exp_wd);
                if (sel_cnt == 1) chk({tag, "_setup_pen"}, 32'(bus.PENABLE), 32'd0);
            end
            if (bus.PENABLE) en_cnt++;
            bus.PREADY  = bus.PENABLE && (en_cnt > waits);
            bus.PSLVERR = slverr;
            bus.PRDATA  = prd;
            if (bus.rsp_valid) done = 1'b1;
            else begin
                @(posedge PCLK);
                lat++;
                @(negedge PCLK);
            end
        end
        bus.PREADY = 1'b0;
        chk({tag, "_rsp_seen"}, 32'(done), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_penable_cycles"}, 32'(en_cnt), 32'(exp_en));
        if (exp_en == 0) chk({tag, "_psel_cycles"}, 32'(sel_cnt), 32'd0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, exp_rd);
        chk({tag, "_busy_req_ready"}, 32'(bus.req_ready), 32'd0);
        if (hold > 0) begin
            bus.req_write = 1'b0;
            bus.req_addr  = 32'h100;
            bus.req_valid = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge PCLK);
                @(negedge PCLK);
                chk({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
                chk({tag, "_hold_req_ready"}, 32'(bus.req_ready), 32'd0);
                chk({tag, "_hold_rdata"}, bus.rsp_rdata, exp_rd);
                chk({tag, "_hold_err"}, 32'(bus.rsp_err), 32'(exp_err));
                chk({tag, "_hold_psel"}, 32'(bus.PSEL), 32'd0);
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        chk({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_next_req_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        PRESET        = 1'b0;

        repeat (2) @(negedge PCLK);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_psel", 32'(bus.PSEL), 32'd0);
        chk("rst_penable", 32'(bus.PENABLE), 32'd0);
        chk("rst_pwrite", 32'(bus.PWRITE), 32'd0);
        chk("rst_paddr", bus.PADDR, 32'h0);
        chk("rst_pwdata", bus.PWDATA, 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        #2 PRESET = 1'b1;
        @(negedge PCLK);
        chk("rel_req_ready", 32'(bus.req_ready), 32'd1);

        // tag, wr, addr, wdata, waits, slverr, prdata, exp_err, exp_rdata, exp_lat, exp_en, hold
        run_xfer("wr0",   1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0,        3, 1, 0);
        run_xfer("rd2w",  1'b0, 32'h40, 32'h0,        2, 1'b0, 32'h12345678, 1'b0, 32'h12345678, 5, 3, 0);
        run_xfer("rderr", 1'b0, 32'h44, 32'h0,        1, 1'b1, 32'hAAAA5555, 1'b1, 32'h0,        4, 2, 0);
        run_xfer("wr_ok", 1'b1, 32'h48, 32'h0BADF00D, 0, 1'b1, 32'h0,        1'b1, 32'h0,        3, 1, 0);
        run_xfer("mis13", 1'b1, 32'h13, 32'h55555555, 0, 1'b0, 32'h0,        1'b1, 32'h0,        1, 0, 0);
        chk("mis13_paddr_kept", bus.PADDR, 32'h48);
        run_xfer("hold",  1'b0, 32'h50, 32'h0,        0, 1'b0, 32'hCAFE0001, 1'b0, 32'hCAFE0001, 3, 1, 4);
        run_xfer("after", 1'b0, 32'h54, 32'h0,        0, 1'b0, 32'h00C0FFEE, 1'b0, 32'h00C0FFEE, 3, 1, 0);

        // Reset pulsed during ACCESS
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h80;
        bus.req_valid = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        bus.req_valid = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        chk("abort_pre_penable", 32'(bus.PENABLE), 32'd1);
        #2 PRESET = 1'b0;
        #1;
        chk("abort_psel", 32'(bus.PSEL), 32'd0);
        chk("abort_penable", 32'(bus.PENABLE), 32'd0);
        chk("abort_paddr", bus.PADDR, 32'h0);
        chk("abort_req_ready", 32'(bus.req_ready), 32'd0);
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        #1 PRESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
            chk("abort_psel_after", 32'(bus.PSEL), 32'd0);
        end
        chk("abort_req_ready_after", 32'(bus.req_ready), 32'd1);

`ifdef APB_MST_TIMEOUT_EN
        run_xfer("tmo",    1'b0, 32'h60, 32'h0, 100, 1'b0, 32'h11111111, 1'b1, 32'h0,        6, 4, 0);
        run_xfer("tmo_ok", 1'b0, 32'h64, 32'h0, 3,   1'b0, 32'h22222222, 1'b0, 32'h22222222, 6, 4, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
